// File: rtl/reset_sequencer.sv
// Central reset controller: merges power, PLL lock, debounced tact switch and soft request,
// asserts every domain reset together, holds, then releases domains one at a time in index order.
module reset_sequencer #(
  parameter int unsigned N_DOMAINS       = 4,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Tact,
  input  logic                 PllLocked,
  input  logic                 SoftReq,
  output logic [N_DOMAINS-1:0] DomReset,
  output logic                 Busy,
  output logic [1:0]           Cause
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [1:0] CAUSE_PLL  = 2'd1;
  localparam logic [1:0] CAUSE_TACT = 2'd2;
  localparam logic [1:0] CAUSE_SOFT = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic          tact_s1, tact_s2;
  logic          pll_s1, pll_s2;
  logic [DW-1:0] deb_cnt;
  logic          deb_lvl;
  logic          press;

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N_DOMAINS-1:0] dom_d;
  logic [1:0]     cause_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tact_s1 <= 1'b0;
      tact_s2 <= 1'b0;
      pll_s1  <= 1'b0;
      pll_s2  <= 1'b0;
    end else begin
      tact_s1 <= Tact;
      tact_s2 <= tact_s1;
      pll_s1  <= PllLocked;
      pll_s2  <= pll_s1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
    end else if (tact_s2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      deb_cnt <= '0;
      deb_lvl <= tact_s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Press is flagged in the same cycle the debounced level is about to rise.
  assign press = tact_s2 & ~deb_lvl & (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_WAIT_LOCK;
      hold_q   <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      DomReset <= '1;
      Busy     <= 1'b1;
      Cause    <= 2'd0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      DomReset <= dom_d;
      Busy     <= |dom_d;
      Cause    <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    dom_d   = DomReset;
    cause_d = Cause;
    if (state_q != S_WAIT_LOCK && !pll_s2) begin
      state_d = S_WAIT_LOCK;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      dom_d   = '1;
      cause_d = CAUSE_PLL;
    end else if (state_q != S_WAIT_LOCK && (press || SoftReq)) begin
      state_d = S_HOLD;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      dom_d   = '1;
      cause_d = press ? CAUSE_TACT : CAUSE_SOFT;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          dom_d  = '1;
          hold_d = '0;
          if (pll_s2) state_d = S_HOLD;
        end
        S_HOLD: begin
          dom_d = '1;
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_d = S_RELEASE;
            hold_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (gap_q == GW'(STAGE_GAP - 1)) begin
            gap_d = '0;
            for (int unsigned i = 0; i < N_DOMAINS; i++) begin
              if (idx_q == IW'(i)) dom_d[i] = 1'b0;
            end
            if (idx_q == IW'(N_DOMAINS - 1)) begin
              state_d = S_RUN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_RUN: begin
          dom_d = '0;
        end
        default: begin
          state_d = S_WAIT_LOCK;
          dom_d   = '1;
        end
      endcase
    end
  end

endmodule
